// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// field positions, FSM encoding and register payload layouts.
package uart_tx_mmio_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned DIV_W       = 16;
    localparam int unsigned DATA_BITS   = 8;    // 8N1 payload width
    localparam int unsigned BIT_IDX_W   = 3;
    localparam int unsigned CNT_FIELD_W = 4;    // STATUS.count field width

    // Register offsets, selected by addr[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // Write-side bit positions
    localparam int unsigned STATUS_OVF_BIT  = 3;
    localparam int unsigned CTRL_TX_EN_BIT  = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;

    // Transmitter states (2-bit)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // STATUS read layout
    typedef struct packed {
        logic [DATA_W-CNT_FIELD_W-5:0] rsvd;
        logic [CNT_FIELD_W-1:0]        count;
        logic                          overflow;
        logic                          busy;
        logic                          empty;
        logic                          full;
    } status_t;

    // CTRL register layout
    typedef struct packed {
        logic irq_en;
        logic tx_en;
    } ctrl_t;

    // Address window decode: 16-byte window, byte offset ignored
    function automatic logic win_hit(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base);
        return addr[ADDR_W-1:4] == base[ADDR_W-1:4];
    endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Single-clock FIFO with show-ahead head data. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module uart_tx_mmio_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data_c,
    output logic             full_c,
    output logic             empty_c,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Flags and accept qualification
    always_comb begin
        full_c     = (count == CNT_W'(DEPTH));
        empty_c    = (count == '0);
        pop_ok     = pop & ~empty_c;
        push_ok    = push & (~full_c | pop_ok);
        pop_data_c = mem[rd_ptr];
    end

    // Storage array, no reset needed: pointers define valid contents
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud timing,
// serialiser FSM and TX-empty interrupt.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned       FIFO_DEPTH  = 8,
    parameter logic [DIV_W-1:0]  DEFAULT_DIV = 16'd433
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              txd_o,
    output logic              irq_o
);

    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    // Configuration / status registers
    logic [DIV_W-1:0]      baud_div;
    ctrl_t                 ctrl;
    logic                  overflow;

    // FIFO interface
    logic                  push_req;
    logic                  fifo_pop;
    logic [DATA_BITS-1:0]  fifo_head_c;
    logic                  fifo_full_c;
    logic                  fifo_empty_c;
    logic [FIFO_CNT_W-1:0] fifo_count;

    // Serialiser state
    tx_state_e             state;
    logic [DIV_W-1:0]      baud_cnt;
    logic [DIV_W-1:0]      cur_div;
    logic [BIT_IDX_W-1:0]  bit_idx;
    logic [DATA_BITS-1:0]  shreg;
    logic                  bit_end;

    // Write decode
    logic                  wr_hit;
    logic [1:0]            wr_reg;
    logic                  ovf_set;
    logic                  ovf_clr;

    // Read path
    logic                  rd_hit;
    status_t               status_c;
    logic [DATA_W-1:0]     rd_value_c;

    // Write-data and address bits that carry no register content
    logic                  unused_bits;
    assign unused_bits = ^{wr_data_i[DATA_W-1:2*DATA_BITS], wr_addr_i[1:0], rd_addr_i[1:0]};

    // Write-side decode and FIFO pop decision
    always_comb begin
        wr_hit   = win_hit(wr_addr_i, BASE_ADDR);
        wr_reg   = wr_addr_i[3:2];
        push_req = wr_hit & (wr_reg == REG_TXDATA) & wr_en_i[0];
        ovf_clr  = wr_hit & (wr_reg == REG_STATUS) & wr_en_i[0] & wr_data_i[STATUS_OVF_BIT];
        bit_end  = (baud_cnt == cur_div);
        fifo_pop = ctrl.tx_en & ~fifo_empty_c &
                   ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));
        ovf_set  = push_req & fifo_full_c & ~fifo_pop;
    end

    uart_tx_mmio_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_req),
        .push_data  (wr_data_i[DATA_BITS-1:0]),
        .pop        (fifo_pop),
        .pop_data_c (fifo_head_c),
        .full_c     (fifo_full_c),
        .empty_c    (fifo_empty_c),
        .count      (fifo_count)
    );

    // Software-visible configuration registers and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_div <= DEFAULT_DIV;
            ctrl     <= '{irq_en: 1'b0, tx_en: 1'b1};
            overflow <= 1'b0;
        end else begin
            if (wr_hit && wr_reg == REG_BAUD) begin
                if (wr_en_i[0]) baud_div[7:0]  <= wr_data_i[7:0];
                if (wr_en_i[1]) baud_div[15:8] <= wr_data_i[15:8];
            end
            if (wr_hit && wr_reg == REG_CTRL && wr_en_i[0]) begin
                ctrl.tx_en  <= wr_data_i[CTRL_TX_EN_BIT];
                ctrl.irq_en <= wr_data_i[CTRL_IRQ_EN_BIT];
            end
            // A same-cycle drop beats a software clear
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Serialiser: start bit, 8 data bits LSB first, stop bit; back-to-back
    // frames start straight from the stop bit without an idle cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            cur_div  <= DEFAULT_DIV;
            bit_idx  <= '0;
            shreg    <= '0;
            txd_o    <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    txd_o    <= 1'b1;
                    baud_cnt <= '0;
                    if (fifo_pop) begin
                        shreg   <= fifo_head_c;
                        cur_div <= baud_div;
                        txd_o   <= 1'b0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        txd_o    <= shreg[0];
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
                            txd_o <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_IDX_W'(1);
                            shreg   <= shreg >> 1;
                            txd_o   <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + DIV_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (fifo_pop) begin
                            shreg   <= fifo_head_c;
                            cur_div <= baud_div;
                            txd_o   <= 1'b0;
                            state   <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + DIV_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // TX-empty interrupt, level, one cycle behind the condition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= ctrl.irq_en & fifo_empty_c & (state == ST_IDLE);
        end
    end

    // Read mux
    always_comb begin
        rd_hit            = win_hit(rd_addr_i, BASE_ADDR);
        status_c          = '0;
        status_c.full     = fifo_full_c;
        status_c.empty    = fifo_empty_c;
        status_c.busy     = (state != ST_IDLE);
        status_c.overflow = overflow;
        status_c.count    = CNT_FIELD_W'(fifo_count);
        rd_value_c        = '0;
        if (rd_hit) begin
            unique case (rd_addr_i[3:2])
                REG_STATUS: rd_value_c = status_c;
                REG_BAUD:   rd_value_c = DATA_W'(baud_div);
                REG_CTRL:   rd_value_c = DATA_W'(ctrl);
                default:    rd_value_c = '0;
            endcase
        end
    end

    // Registered read data, one cycle after the address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= rd_value_c;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio: register vector table, directed frame/overflow/
// interrupt/reset sequences, and randomized bursts checked by a frame monitor.
module tb_uart_tx_mmio;

    localparam logic [31:0] A_TX = 32'h1000_0000;
    localparam logic [31:0] A_ST = 32'h1000_0004;
    localparam logic [31:0] A_BD = 32'h1000_0008;
    localparam logic [31:0] A_CT = 32'h1000_000C;

    logic        clk;
    logic        rst;
    logic [3:0]  wr_en_i;
    logic [31:0] wr_addr_i;
    logic [31:0] wr_data_i;
    logic [31:0] rd_addr_i;
    logic [31:0] rd_data_o;
    logic        txd_o;
    logic        irq_o;

    int n_checks;
    int n_errors;

    // Frame monitor state: expected byte queue and bit period in clocks-1
    logic [7:0] exp_q [$];
    int         mon_div;
    bit         mon_en;

    uart_tx_mmio #(
        .BASE_ADDR   (32'h1000_0000),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o),
        .txd_o     (txd_o),
        .irq_o     (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wa;
        logic [3:0]  we;
        logic [31:0] wd;
        logic [31:0] ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge
    task automatic do_write(input logic [31:0] a, input logic [3:0] en, input logic [31:0] d);
        wr_addr_i = a;
        wr_en_i   = en;
        wr_data_i = d;
        @(negedge clk);
        wr_en_i = 4'b0000;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        rd_addr_i = a;
        @(negedge clk);
        d = rd_data_o;
    endtask

    task automatic wait_idle(input int max_cycles);
        logic [31:0] d;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            do_read(A_ST, d);
            if (d[1] && !d[2]) ok = 1'b1;
        end
        check("wait_idle", 32'(ok), 32'd1);
    endtask

    // Compare txd_o cycle by cycle with nf frames of p clocks per bit;
    // the current negedge is the first start-bit cycle. STATUS must be on rd_addr_i.
    task automatic check_serial(input logic [7:0] b0, input logic [7:0] b1, input int nf, input int p);
        logic [9:0] fr [2];
        logic       exp_b;
        int         len;
        int         idx;
        int         busy_sum;
        fr[0]    = {1'b1, b0, 1'b0};
        fr[1]    = {1'b1, b1, 1'b0};
        len      = nf * 10 * p;
        busy_sum = 0;
        for (int k = 0; k < len + 2; k++) begin
            if (k > 0) @(negedge clk);
            if (k < len) begin
                idx   = k / p;
                exp_b = fr[idx / 10][idx % 10];
            end else begin
                exp_b = 1'b1;
            end
            check($sformatf("txd k=%0d", k), 32'(txd_o), 32'(exp_b));
            busy_sum += int'(rd_data_o[2]);
        end
        check("busy_cycles", 32'(busy_sum), 32'(len));
    endtask

    // Monitor one frame starting at the current negedge
    task automatic mon_frame();
        logic [7:0] b;
        logic [7:0] rx;
        logic [9:0] fr;
        int         p;
        int         errs;
        p    = mon_div + 1;
        errs = 0;
        rx   = '0;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_frame: start bit seen with no byte expected");
            b = 8'h00;
        end else begin
            b = exp_q.pop_front();
        end
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 10 * p; k++) begin
            if (k > 0) @(negedge clk);
            if (txd_o !== fr[k / p]) errs++;
            if (k / p >= 1 && k / p <= 8 && k % p == p / 2) rx[k / p - 1] = txd_o;
        end
        check("mon_rx_byte", 32'(rx), 32'(b));
        check("mon_frame_shape", 32'(errs), 32'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && txd_o === 1'b0) mon_frame();
        end
    end

    // Hang guard
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          low;
        int          zeros;
        bit          back;
        int          n;
        int          dv;
        logic [7:0]  b;

        n_checks  = 0;
        n_errors  = 0;
        mon_en    = 1'b0;
        mon_div   = 3;
        rst       = 1'b1;
        wr_en_i   = 4'b0000;
        wr_addr_i = '0;
        wr_data_i = '0;
        rd_addr_i = '0;

        vecs[0]  = '{32'h0, 4'b0000, 32'h0,          A_ST,           32'h0000_0002};
        vecs[1]  = '{32'h0, 4'b0000, 32'h0,          A_BD,           32'd433};
        vecs[2]  = '{32'h0, 4'b0000, 32'h0,          A_CT,           32'h0000_0001};
        vecs[3]  = '{32'h0, 4'b0000, 32'h0,          A_TX,           32'h0000_0000};
        vecs[4]  = '{32'h0, 4'b0000, 32'h0,          32'h1000_0010,  32'h0000_0000};
        vecs[5]  = '{32'h0, 4'b0000, 32'h0,          32'h0FFF_FFFC,  32'h0000_0000};
        vecs[6]  = '{32'h0, 4'b0000, 32'h0,          32'h1000_0007,  32'h0000_0002};
        vecs[7]  = '{A_BD,  4'b0001, 32'h0000_1234,  A_BD,           32'h0000_0134};
        vecs[8]  = '{A_BD,  4'b0010, 32'h0000_5600,  A_BD,           32'h0000_5634};
        vecs[9]  = '{A_BD,  4'b1100, 32'hFFFF_FFFF,  A_BD,           32'h0000_5634};
        vecs[10] = '{A_BD,  4'b0011, 32'hABCD_0003,  A_BD,           32'h0000_0003};
        vecs[11] = '{32'h2000_0008, 4'b1111, 32'h7,  A_BD,           32'h0000_0003};
        vecs[12] = '{A_CT,  4'b0001, 32'h0000_0000,  A_CT,           32'h0000_0000};
        vecs[13] = '{A_CT,  4'b0010, 32'h0000_0003,  A_CT,           32'h0000_0000};
        vecs[14] = '{A_TX,  4'b1110, 32'h0000_00AB,  A_ST,           32'h0000_0002};
        vecs[15] = '{A_TX,  4'b0001, 32'hFFFF_FFAB,  A_ST,           32'h0000_0010};
        vecs[16] = '{A_ST,  4'b0001, 32'h0000_0008,  A_ST,           32'h0000_0010};
        vecs[17] = '{A_CT,  4'b0001, 32'h0000_0001,  A_CT,           32'h0000_0001};

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_txd", 32'(txd_o), 32'd1);
        check("reset_irq", 32'(irq_o), 32'd0);
        check("reset_rd_data", rd_data_o, 32'd0);

        // Register vector table
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].we != 4'b0000) do_write(vecs[i].wa, vecs[i].we, vecs[i].wd);
            do_read(vecs[i].ra, d);
            check($sformatf("vec[%0d]", i), d, vecs[i].exp);
        end
        wait_idle(200);

        // Single frame, 4 clocks per bit
        do_write(A_BD, 4'b0011, 32'd3);
        rd_addr_i = A_ST;
        wr_addr_i = A_TX; wr_data_i = 32'h55; wr_en_i = 4'b0001;
        @(negedge clk);
        wr_en_i = 4'b0000;
        check("txd_pre_start", 32'(txd_o), 32'd1);
        @(negedge clk);
        check_serial(8'h55, 8'h00, 1, 4);

        // Back-to-back frames from consecutive writes
        rd_addr_i = A_ST;
        wr_addr_i = A_TX; wr_data_i = 32'hA5; wr_en_i = 4'b0001;
        @(negedge clk);
        wr_data_i = 32'h0F;
        @(negedge clk);
        wr_en_i = 4'b0000;
        check_serial(8'hA5, 8'h0F, 2, 4);

        // Overflow with transmitter disabled
        do_write(A_CT, 4'b0001, 32'h0);
        for (int i = 0; i < 9; i++) do_write(A_TX, 4'b0001, 32'(i));
        do_read(A_ST, d);
        check("status_overflow", d, 32'h0000_0089);
        do_write(A_ST, 4'b0001, 32'h8);
        do_read(A_ST, d);
        check("status_ovf_cleared", d, 32'h0000_0081);

        // Push into a full FIFO in the same cycle as the first pop is accepted
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h99);
        mon_div = 3;
        mon_en  = 1'b1;
        wr_addr_i = A_CT; wr_data_i = 32'h1; wr_en_i = 4'b0001;
        @(negedge clk);
        wr_addr_i = A_TX; wr_data_i = 32'h99;
        @(negedge clk);
        wr_en_i = 4'b0000;
        do_read(A_ST, d);
        check("status_push_with_pop", d, 32'h0000_0085);
        wait_idle(1000);
        repeat (4) @(negedge clk);
        check("drain_all_received", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        // Interrupt
        do_write(A_BD, 4'b0011, 32'd1);
        do_write(A_CT, 4'b0001, 32'h3);
        @(negedge clk);
        check("irq_idle_enabled", 32'(irq_o), 32'd1);
        wr_addr_i = A_TX; wr_data_i = 32'h00; wr_en_i = 4'b0001;
        @(negedge clk);
        wr_en_i = 4'b0000;
        check("irq_before_pop", 32'(irq_o), 32'd1);
        low  = 0;
        back = 1'b0;
        for (int i = 0; i < 200 && !back; i++) begin
            @(negedge clk);
            if (irq_o) back = 1'b1;
            else low++;
        end
        check("irq_returns", 32'(back), 32'd1);
        check("irq_low_cycles", 32'(low), 32'd21);
        do_write(A_CT, 4'b0001, 32'h1);
        @(negedge clk);
        check("irq_disabled", 32'(irq_o), 32'd0);

        // Randomized bursts against the byte-queue model
        exp_q.delete();
        mon_en = 1'b1;
        for (int t = 0; t < 6; t++) begin
            dv = int'($urandom_range(0, 5));
            do_write(A_BD, 4'b0011, 32'(dv));
            mon_div = dv;
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                do_write(A_TX, 4'($urandom) | 4'b0001, {24'($urandom), b});
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle(1000);
            repeat (3) @(negedge clk);
            check($sformatf("rand_burst%0d_done", t), 32'(exp_q.size()), 32'd0);
        end
        mon_en = 1'b0;
        do_read(A_ST, d);
        check("rand_no_overflow", 32'(d[3]), 32'd0);

        // Reset during data bit 3 with two bytes queued
        do_write(A_BD, 4'b0011, 32'd3);
        wr_addr_i = A_TX; wr_data_i = 32'h00; wr_en_i = 4'b0001;
        @(negedge clk);
        wr_data_i = 32'h11;
        @(negedge clk);
        wr_data_i = 32'h22;
        @(negedge clk);
        wr_en_i = 4'b0000;
        repeat (16) @(negedge clk);
        check("txd_data_bit3", 32'(txd_o), 32'd0);
        #2 rst = 1'b1;
        #1 check("txd_async_reset", 32'(txd_o), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("irq_after_reset", 32'(irq_o), 32'd0);
        do_read(A_ST, d);
        check("status_after_reset", d, 32'h0000_0002);
        do_read(A_BD, d);
        check("baud_after_reset", d, 32'd433);
        do_read(A_CT, d);
        check("ctrl_after_reset", d, 32'h0000_0001);
        zeros = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd_o !== 1'b1) zeros++;
        end
        check("no_frames_after_reset", 32'(zeros), 32'd0);
        do_read(A_ST, d);
        check("status_still_empty", d, 32'h0000_0002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
